// File: rtl/rbcp_reg_slave.sv
// SiTCP RBCP register slave: ID/version, scratch word, run/pulse control, counter snapshot.
// Fixed two-cycle strobe-to-ACK latency; no backpressure, strobes outside IDLE are dropped.
module rbcp_reg_slave #(
   parameter logic [23:0] BASE_ADDR = 24'h000000,
   parameter logic [7:0]  DEVICE_ID = 8'hA5,
   parameter logic [7:0]  VERSION   = 8'h01,
   // reset value of the cycle counter; left at zero except to reach wrap quickly
   parameter logic [31:0] CNT_INIT  = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        RBCP_ACT,
   input  logic [31:0] RBCP_ADDR,
   input  logic        RBCP_WE,
   input  logic [7:0]  RBCP_WD,
   input  logic        RBCP_RE,
   output logic        RBCP_ACK,
   output logic [7:0]  RBCP_RD,
   output logic        CTRL_RUN,
   output logic        CTRL_PULSE,
   output logic [31:0] SCRATCH
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ACK  = 2'd2
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic        hit;
   logic        lat_en;
   logic        commit;

   logic [7:0]  off_q;
   logic [7:0]  wd_q;
   logic        wr_q;
   logic [7:0]  rd_q;
   logic [7:0]  rd_sel;

   logic [31:0] scratch_q;
   logic        run_q;
   logic        pulse_q;
   logic [31:0] cnt_q;
   logic [23:0] shadow_q;

   assign hit = RBCP_ACT && (RBCP_WE || RBCP_RE) && (RBCP_ADDR[31:8] == BASE_ADDR);

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ACT falling while BUSY means SiTCP gave up: abort without commit or ACK
   always_comb begin
      state_d = state_q;
      lat_en  = 1'b0;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (hit) begin
               lat_en  = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (RBCP_ACT) begin
               commit  = 1'b1;
               state_d = ACK;
            end else begin
               state_d = IDLE;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      rd_sel = 8'h00;
      case (off_q)
         8'h00:   rd_sel = DEVICE_ID;
         8'h01:   rd_sel = VERSION;
         8'h04:   rd_sel = scratch_q[7:0];
         8'h05:   rd_sel = scratch_q[15:8];
         8'h06:   rd_sel = scratch_q[23:16];
         8'h07:   rd_sel = scratch_q[31:24];
         8'h08:   rd_sel = {7'b0, run_q};
         8'h10:   rd_sel = cnt_q[7:0];
         8'h11:   rd_sel = shadow_q[7:0];
         8'h12:   rd_sel = shadow_q[15:8];
         8'h13:   rd_sel = shadow_q[23:16];
         default: rd_sel = 8'h00;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         off_q     <= 8'h00;
         wd_q      <= 8'h00;
         wr_q      <= 1'b0;
         rd_q      <= 8'h00;
         scratch_q <= 32'h0;
         run_q     <= 1'b0;
         pulse_q   <= 1'b0;
         cnt_q     <= CNT_INIT;
         shadow_q  <= 24'h0;
      end else begin
         cnt_q   <= cnt_q + 32'd1;
         pulse_q <= 1'b0;
         if (lat_en) begin
            off_q <= RBCP_ADDR[7:0];
            wd_q  <= RBCP_WD;
            wr_q  <= RBCP_WE;
         end
         if (commit) begin
            if (wr_q) begin
               rd_q <= 8'h00;
               case (off_q)
                  8'h04:   scratch_q[7:0]   <= wd_q;
                  8'h05:   scratch_q[15:8]  <= wd_q;
                  8'h06:   scratch_q[23:16] <= wd_q;
                  8'h07:   scratch_q[31:24] <= wd_q;
                  8'h08:   run_q            <= wd_q[0];
                  8'h09:   pulse_q          <= wd_q[0];
                  default: ;
               endcase
            end else begin
               rd_q <= rd_sel;
               // upper bytes frozen together with the low byte so a 4-byte read is coherent
               if (off_q == 8'h10) begin
                  shadow_q <= cnt_q[31:8];
               end
            end
         end
      end
   end

   assign RBCP_ACK   = (state_q == ACK);
   assign RBCP_RD    = (state_q == ACK) ? rd_q : 8'h00;
   assign CTRL_RUN   = run_q;
   assign CTRL_PULSE = pulse_q;
   assign SCRATCH    = scratch_q;

endmodule

// File: tb/tb_rbcp_reg_slave.sv
// Bench for rbcp_reg_slave: directed scenarios plus random accesses against a register-map model.
module tb_rbcp_reg_slave;

   localparam logic [31:0] CNT_INIT = 32'hFFFF_F000;

   logic        CLK;
   logic        RSTn;
   logic        RBCP_ACT;
   logic [31:0] RBCP_ADDR;
   logic        RBCP_WE;
   logic [7:0]  RBCP_WD;
   logic        RBCP_RE;
   logic        RBCP_ACK;
   logic [7:0]  RBCP_RD;
   logic        CTRL_RUN;
   logic        CTRL_PULSE;
   logic [31:0] SCRATCH;

   int checks = 0;
   int errors = 0;

   rbcp_reg_slave #(
      .BASE_ADDR (24'h000000),
      .DEVICE_ID (8'hA5),
      .VERSION   (8'h01),
      .CNT_INIT  (CNT_INIT)
   ) dut (
      .CLK        (CLK),
      .RSTn       (RSTn),
      .RBCP_ACT   (RBCP_ACT),
      .RBCP_ADDR  (RBCP_ADDR),
      .RBCP_WE    (RBCP_WE),
      .RBCP_WD    (RBCP_WD),
      .RBCP_RE    (RBCP_RE),
      .RBCP_ACK   (RBCP_ACK),
      .RBCP_RD    (RBCP_RD),
      .CTRL_RUN   (CTRL_RUN),
      .CTRL_PULSE (CTRL_PULSE),
      .SCRATCH    (SCRATCH)
   );

   initial CLK = 1'b0;
   always #2 CLK = ~CLK;

   // rising edges seen since reset release: the counter equals CNT_INIT plus this
   logic [31:0] edges;
   always @(posedge CLK or negedge RSTn) begin
      if (!RSTn) edges <= 32'd0;
      else       edges <= edges + 32'd1;
   end

   // register-map model
   logic [31:0] m_scr;
   logic        m_run;
   logic [23:0] m_shadow;

   // observations of one access, cycles N+1 .. N+3 after the strobe cycle N
   logic        o_ack1, o_ack2, o_ack3, o_pulse1, o_pulse2, o_pulse3, o_run2;
   logic [7:0]  o_rd2;
   logic [31:0] o_scr1, o_scr2, o_cnt;

   task automatic model_reset();
      m_scr    = 32'h0;
      m_run    = 1'b0;
      m_shadow = 24'h0;
   endtask

   task automatic model_apply(input logic [31:0] addr, input logic we, input logic re,
                              input logic [7:0] wd, input logic drop, input logic [31:0] cnt,
                              output logic e_ack, output logic [7:0] e_rd, output logic e_pulse);
      int off;
      e_ack   = 1'b0;
      e_rd    = 8'h00;
      e_pulse = 1'b0;
      off     = int'(addr[7:0]);
      if ((we || re) && addr[31:8] == 24'h0 && !drop) begin
         e_ack = 1'b1;
         if (we) begin
            if (off >= 4 && off <= 7) m_scr[(off-4)*8 +: 8] = wd;
            else if (off == 8)        m_run = wd[0];
            else if (off == 9)        e_pulse = wd[0];
         end else begin
            if (off == 0)                    e_rd = 8'hA5;
            else if (off == 1)               e_rd = 8'h01;
            else if (off >= 4 && off <= 7)   e_rd = m_scr[(off-4)*8 +: 8];
            else if (off == 8)               e_rd = {7'b0, m_run};
            else if (off == 16) begin
               e_rd     = cnt[7:0];
               m_shadow = cnt[31:8];
            end
            else if (off >= 17 && off <= 19) e_rd = m_shadow[(off-17)*8 +: 8];
         end
      end
   endtask

   task automatic drive(input logic [31:0] addr, input logic we, input logic re,
                        input logic [7:0] wd, input logic drop);
      @(negedge CLK);
      RBCP_ACT = 1'b1; RBCP_ADDR = addr; RBCP_WE = we; RBCP_RE = re; RBCP_WD = wd;
      @(negedge CLK);
      RBCP_WE = 1'b0; RBCP_RE = 1'b0;
      if (drop) RBCP_ACT = 1'b0;
      o_ack1 = RBCP_ACK; o_scr1 = SCRATCH; o_pulse1 = CTRL_PULSE; o_cnt = CNT_INIT + edges;
      @(negedge CLK);
      RBCP_ACT = 1'b0;
      o_ack2 = RBCP_ACK; o_rd2 = RBCP_RD; o_scr2 = SCRATCH; o_run2 = CTRL_RUN; o_pulse2 = CTRL_PULSE;
      @(negedge CLK);
      o_ack3 = RBCP_ACK; o_pulse3 = CTRL_PULSE;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RSTn = 1'b0; RBCP_ACT = 1'b0; RBCP_WE = 1'b0; RBCP_RE = 1'b0;
      model_reset();
      repeat (2) @(negedge CLK);
      RSTn = 1'b1;
   endtask

   task automatic test_reset();
      logic e_ack, e_pulse;
      logic [7:0] e_rd;
      @(negedge CLK);
      RSTn = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({RBCP_ACK, RBCP_RD, CTRL_RUN, CTRL_PULSE, SCRATCH} !== 43'h0) begin
         errors++;
         $display("FAIL reset_outputs: ack=%b rd=%h run=%b pulse=%b scratch=%h, want all zero",
                  RBCP_ACK, RBCP_RD, CTRL_RUN, CTRL_PULSE, SCRATCH);
      end
      @(negedge CLK);
      // strobe presented so that it is sampled on the first edge with reset released
      RSTn = 1'b1; RBCP_ACT = 1'b1; RBCP_ADDR = 32'h0; RBCP_RE = 1'b1;
      @(negedge CLK);
      RBCP_RE = 1'b0;
      checks++;
      if (RBCP_ACK !== 1'b0) begin
         errors++; $display("FAIL first_strobe_early_ack: ack=%b want 0", RBCP_ACK);
      end
      @(negedge CLK);
      RBCP_ACT = 1'b0;
      checks++;
      if (RBCP_ACK !== 1'b1 || RBCP_RD !== 8'hA5) begin
         errors++; $display("FAIL first_strobe: ack=%b rd=%h want ack=1 rd=a5", RBCP_ACK, RBCP_RD);
      end
      drive(32'h11, 1'b0, 1'b1, 8'h00, 1'b0);
      model_apply(32'h11, 1'b0, 1'b1, 8'h00, 1'b0, o_cnt, e_ack, e_rd, e_pulse);
      checks++;
      if (o_ack2 !== 1'b1 || o_rd2 !== 8'h00) begin
         errors++; $display("FAIL reset_shadow: ack=%b rd=%h want ack=1 rd=00", o_ack2, o_rd2);
      end
      drive(32'h10, 1'b0, 1'b1, 8'h00, 1'b0);
      model_apply(32'h10, 1'b0, 1'b1, 8'h00, 1'b0, o_cnt, e_ack, e_rd, e_pulse);
      checks++;
      if (o_ack2 !== 1'b1 || o_rd2 !== e_rd) begin
         errors++; $display("FAIL reset_counter: ack=%b rd=%h want ack=1 rd=%h", o_ack2, o_rd2, e_rd);
      end
   endtask

   task automatic test_id();
      logic e_ack, e_pulse;
      logic [7:0] e_rd;
      logic [7:0] exp_id [2] = '{8'hA5, 8'h01};
      for (int i = 0; i < 2; i++) begin
         drive(32'(i), 1'b0, 1'b1, 8'h00, 1'b0);
         model_apply(32'(i), 1'b0, 1'b1, 8'h00, 1'b0, o_cnt, e_ack, e_rd, e_pulse);
         checks++;
         if (o_ack1 !== 1'b0 || o_ack2 !== 1'b1 || o_ack3 !== 1'b0 || o_rd2 !== exp_id[i]) begin
            errors++;
            $display("FAIL id_read[%0d]: ack=%b%b%b rd=%h want ack=010 rd=%h",
                     i, o_ack1, o_ack2, o_ack3, o_rd2, exp_id[i]);
         end
      end
   endtask

   task automatic test_scratch();
      logic e_ack, e_pulse;
      logic [7:0] e_rd;
      logic [7:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
         drive(32'(4 + i), 1'b1, 1'b0, d[i], 1'b0);
         model_apply(32'(4 + i), 1'b1, 1'b0, d[i], 1'b0, o_cnt, e_ack, e_rd, e_pulse);
         checks++;
         if (o_ack1 !== 1'b0 || o_ack2 !== 1'b1 || o_ack3 !== 1'b0 || o_scr2 !== m_scr) begin
            errors++;
            $display("FAIL scratch_write[%0d]: ack=%b%b%b scratch=%h want ack=010 scratch=%h",
                     i, o_ack1, o_ack2, o_ack3, o_scr2, m_scr);
         end
      end
      checks++;
      if (SCRATCH !== 32'h44332211) begin
         errors++; $display("FAIL scratch_word: got %h want 44332211", SCRATCH);
      end
      for (int i = 0; i < 4; i++) begin
         drive(32'(4 + i), 1'b0, 1'b1, 8'h00, 1'b0);
         checks++;
         if (o_ack2 !== 1'b1 || o_rd2 !== d[i]) begin
            errors++; $display("FAIL scratch_read[%0d]: ack=%b rd=%h want ack=1 rd=%h", i, o_ack2, o_rd2, d[i]);
         end
      end
   endtask

   task automatic test_ctrl();
      logic e_ack, e_pulse;
      logic [7:0] e_rd;
      drive(32'h08, 1'b1, 1'b0, 8'hFF, 1'b0);
      model_apply(32'h08, 1'b1, 1'b0, 8'hFF, 1'b0, o_cnt, e_ack, e_rd, e_pulse);
      checks++;
      if (o_run2 !== 1'b1 || o_ack2 !== 1'b1) begin
         errors++; $display("FAIL run_write: run=%b ack=%b want 1 1", o_run2, o_ack2);
      end
      drive(32'h08, 1'b0, 1'b1, 8'h00, 1'b0);
      checks++;
      if (o_rd2 !== 8'h01) begin
         errors++; $display("FAIL run_read: got %h want 01", o_rd2);
      end
      drive(32'h09, 1'b1, 1'b0, 8'h01, 1'b0);
      model_apply(32'h09, 1'b1, 1'b0, 8'h01, 1'b0, o_cnt, e_ack, e_rd, e_pulse);
      checks++;
      if ({o_pulse1, o_pulse2, o_pulse3} !== 3'b010 || o_ack2 !== 1'b1) begin
         errors++; $display("FAIL pulse_one: pulse=%b%b%b ack=%b want 010 1", o_pulse1, o_pulse2, o_pulse3, o_ack2);
      end
      drive(32'h09, 1'b1, 1'b0, 8'h00, 1'b0);
      checks++;
      if ({o_pulse1, o_pulse2, o_pulse3} !== 3'b000 || o_ack2 !== 1'b1) begin
         errors++; $display("FAIL pulse_zero: pulse=%b%b%b ack=%b want 000 1", o_pulse1, o_pulse2, o_pulse3, o_ack2);
      end
      drive(32'h09, 1'b0, 1'b1, 8'h00, 1'b0);
      checks++;
      if (o_ack2 !== 1'b1 || o_rd2 !== 8'h00) begin
         errors++; $display("FAIL pulse_read: ack=%b rd=%h want 1 00", o_ack2, o_rd2);
      end
   endtask

   task automatic test_window();
      logic [31:0] addrs [3] = '{32'h0000_0100, 32'hFFFF_FF04, 32'h0001_0008};
      for (int i = 0; i < 3; i++) begin
         drive(addrs[i], 1'b1, 1'b0, 8'h5C, 1'b0);
         checks++;
         if ({o_ack1, o_ack2, o_ack3} !== 3'b000 || o_scr2 !== m_scr || o_run2 !== m_run) begin
            errors++;
            $display("FAIL window_write[%0d]: ack=%b%b%b scratch=%h run=%b want 000 %h %b",
                     i, o_ack1, o_ack2, o_ack3, o_scr2, o_run2, m_scr, m_run);
         end
      end
      drive(32'h0000_0100, 1'b0, 1'b1, 8'h00, 1'b0);
      checks++;
      if ({o_ack1, o_ack2, o_ack3} !== 3'b000 || o_rd2 !== 8'h00) begin
         errors++; $display("FAIL window_read: ack=%b%b%b rd=%h want 000 00", o_ack1, o_ack2, o_ack3, o_rd2);
      end
   endtask

   task automatic test_strobe_busy();
      int n_ack = 0;
      @(negedge CLK);
      RBCP_ACT = 1'b1; RBCP_ADDR = 32'h05; RBCP_WE = 1'b1; RBCP_WD = 8'h77;
      @(negedge CLK);
      n_ack += int'(RBCP_ACK);
      RBCP_WD = 8'h99;
      @(negedge CLK);
      n_ack += int'(RBCP_ACK);
      @(negedge CLK);
      n_ack += int'(RBCP_ACK);
      RBCP_WE = 1'b0; RBCP_ACT = 1'b0;
      repeat (3) begin
         @(negedge CLK);
         n_ack += int'(RBCP_ACK);
      end
      m_scr[15:8] = 8'h77;
      checks++;
      if (n_ack != 1 || SCRATCH !== m_scr) begin
         errors++; $display("FAIL strobe_busy: acks=%0d scratch=%h want 1 %h", n_ack, SCRATCH, m_scr);
      end
   endtask

   task automatic test_we_re();
      logic e_ack, e_pulse;
      logic [7:0] e_rd;
      drive(32'h06, 1'b1, 1'b1, 8'hC3, 1'b0);
      model_apply(32'h06, 1'b1, 1'b1, 8'hC3, 1'b0, o_cnt, e_ack, e_rd, e_pulse);
      checks++;
      if ({o_ack1, o_ack2, o_ack3} !== 3'b010 || o_scr2[23:16] !== 8'hC3 || o_scr2 !== m_scr) begin
         errors++;
         $display("FAIL we_re: ack=%b%b%b scratch=%h want 010 %h", o_ack1, o_ack2, o_ack3, o_scr2, m_scr);
      end
   endtask

   task automatic test_abort();
      int n_ack = 0;
      logic bad_run = 1'b0;
      drive(32'h04, 1'b1, 1'b0, 8'h5A, 1'b1);
      checks++;
      if ({o_ack1, o_ack2, o_ack3} !== 3'b000 || o_scr2 !== m_scr) begin
         errors++;
         $display("FAIL act_drop: ack=%b%b%b scratch=%h want 000 %h", o_ack1, o_ack2, o_ack3, o_scr2, m_scr);
      end
      @(negedge CLK);
      RBCP_ACT = 1'b1; RBCP_ADDR = 32'h08; RBCP_WE = 1'b1; RBCP_WD = 8'h01;
      @(negedge CLK);
      RBCP_WE = 1'b0;
      RSTn = 1'b0;
      model_reset();
      #1;
      checks++;
      if (RBCP_ACK !== 1'b0 || RBCP_RD !== 8'h00 || CTRL_RUN !== 1'b0 || SCRATCH !== 32'h0) begin
         errors++;
         $display("FAIL busy_reset_now: ack=%b rd=%h run=%b scratch=%h want 0 00 0 0",
                  RBCP_ACK, RBCP_RD, CTRL_RUN, SCRATCH);
      end
      @(negedge CLK);
      RSTn = 1'b1;
      repeat (4) begin
         @(negedge CLK);
         n_ack += int'(RBCP_ACK);
         if (CTRL_RUN !== 1'b0 || CTRL_PULSE !== 1'b0) bad_run = 1'b1;
      end
      RBCP_ACT = 1'b0;
      checks++;
      if (n_ack != 0 || bad_run || SCRATCH !== 32'h0) begin
         errors++;
         $display("FAIL busy_reset_after: acks=%0d run_or_pulse_set=%b scratch=%h want 0 0 0",
                  n_ack, bad_run, SCRATCH);
      end
   endtask

   task automatic test_counter();
      logic e_ack, e_pulse;
      logic [7:0] e_rd;
      int guard = 0;
      logic [31:0] snap;
      do_reset();
      while ((CNT_INIT + edges) != 32'hFFFF_FFFC && guard < 6000) begin
         @(negedge CLK);
         guard++;
      end
      checks++;
      if (guard >= 6000) begin
         errors++; $display("FAIL counter_wait: counter %h never reached fffffffc", CNT_INIT + edges);
      end
      drive(32'h10, 1'b0, 1'b1, 8'h00, 1'b0);
      snap = o_cnt;
      model_apply(32'h10, 1'b0, 1'b1, 8'h00, 1'b0, o_cnt, e_ack, e_rd, e_pulse);
      checks++;
      if (o_ack2 !== 1'b1 || o_rd2 !== e_rd || snap !== 32'hFFFF_FFFE) begin
         errors++; $display("FAIL counter_lo: rd=%h want %h (snapshot %h)", o_rd2, e_rd, snap);
      end
      for (int k = 0; k < 4; k++) begin
         logic [31:0] a;
         a = (k == 3) ? 32'h11 : 32'(17 + k);
         drive(a, 1'b0, 1'b1, 8'h00, 1'b0);
         checks++;
         if (o_ack2 !== 1'b1 || o_rd2 !== 8'hFF) begin
            errors++; $display("FAIL counter_shadow[%0d]: ack=%b rd=%h want 1 ff", k, o_ack2, o_rd2);
         end
      end
      drive(32'h10, 1'b0, 1'b1, 8'h00, 1'b0);
      model_apply(32'h10, 1'b0, 1'b1, 8'h00, 1'b0, o_cnt, e_ack, e_rd, e_pulse);
      checks++;
      if (o_rd2 !== e_rd) begin
         errors++; $display("FAIL counter_after_wrap: rd=%h want %h", o_rd2, e_rd);
      end
      drive(32'h11, 1'b0, 1'b1, 8'h00, 1'b0);
      checks++;
      if (o_rd2 !== 8'h00) begin
         errors++; $display("FAIL counter_shadow_wrapped: rd=%h want 00", o_rd2);
      end
   endtask

   task automatic test_random();
      logic [7:0] offs [16] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                                8'h09, 8'h0A, 8'h10, 8'h11, 8'h12, 8'h13, 8'hFF, 8'h03};
      for (int it = 0; it < 150; it++) begin
         logic [31:0] addr, old_scr;
         logic we, re, drop, e_ack, e_pulse;
         logic [7:0] wd, e_rd;
         int sel;
         addr = {24'h0, offs[$urandom_range(0, 15)]};
         if ($urandom_range(0, 7) == 0) addr[31:8] = 24'($urandom_range(1, 32'h00FF_FFFF));
         sel = int'($urandom_range(0, 9));
         we = (sel <= 3) || (sel == 8);
         re = (sel >= 4) && (sel <= 8);
         wd = 8'($urandom_range(0, 255));
         drop = ($urandom_range(0, 9) == 0);
         old_scr = m_scr;
         drive(addr, we, re, wd, drop);
         model_apply(addr, we, re, wd, drop, o_cnt, e_ack, e_rd, e_pulse);
         checks++;
         if (o_ack1 !== 1'b0 || o_ack2 !== e_ack || o_ack3 !== 1'b0) begin
            errors++;
            $display("FAIL rand_ack[%0d]: addr=%h we=%b re=%b drop=%b ack=%b%b%b want 0%b0",
                     it, addr, we, re, drop, o_ack1, o_ack2, o_ack3, e_ack);
         end
         checks++;
         if ((!we || !e_ack) && o_rd2 !== e_rd) begin
            errors++; $display("FAIL rand_rd[%0d]: addr=%h rd=%h want %h", it, addr, o_rd2, e_rd);
         end
         checks++;
         if (o_scr1 !== old_scr || o_scr2 !== m_scr || o_run2 !== m_run) begin
            errors++;
            $display("FAIL rand_regs[%0d]: addr=%h scratch=%h->%h run=%b want %h->%h %b",
                     it, addr, o_scr1, o_scr2, o_run2, old_scr, m_scr, m_run);
         end
         checks++;
         if ({o_pulse1, o_pulse2, o_pulse3} !== {1'b0, e_pulse, 1'b0}) begin
            errors++;
            $display("FAIL rand_pulse[%0d]: addr=%h pulse=%b%b%b want 0%b0",
                     it, addr, o_pulse1, o_pulse2, o_pulse3, e_pulse);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      RSTn = 1'b0; RBCP_ACT = 1'b0; RBCP_ADDR = 32'h0; RBCP_WE = 1'b0; RBCP_RE = 1'b0; RBCP_WD = 8'h00;
      model_reset();
      repeat (2) @(negedge CLK);
      test_reset();
      test_id();
      test_scratch();
      test_ctrl();
      test_window();
      test_strobe_busy();
      test_we_re();
      test_abort();
      test_counter();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rbcp_reg_slave.md
RBCP_REG_SLAVE -- requirements
Module: rbcp_reg_slave

Interface
REQ-001 Parameter: BASE_ADDR, 24'h000000, RBCP_ADDR[31:8] value selecting this block's 256-byte window.
REQ-002 Parameter: DEVICE_ID, 8'hA5, read-only ID byte.
REQ-003 Parameter: VERSION, 8'h01, read-only version byte.
REQ-004 Port: CLK  in  1  system clock; SiTCP user side, 250 MHz; all logic on rising edge.
REQ-005 Port: RSTn  in  1  reset, asynchronous assert, active-low (one clock; reset asynchronous, active-low).
REQ-006 Port: RBCP_ACT  in  1  RBCP transaction active, from SiTCP.
REQ-007 Port: RBCP_ADDR  in  32  byte address.
REQ-008 Port: RBCP_WE  in  1  one-cycle write strobe.
REQ-009 Port: RBCP_WD  in  8  write data.
REQ-010 Port: RBCP_RE  in  1  one-cycle read strobe.
REQ-011 Port: RBCP_ACK  out  1  one-cycle access acknowledge, to SiTCP.
REQ-012 Port: RBCP_RD  out  8  read data, valid only while RBCP_ACK=1, else 8'h00.
REQ-013 Port: CTRL_RUN  out  1  run-enable level, register 0x08 bit0.
REQ-014 Port: CTRL_PULSE  out  1  one-cycle pulse on write of 1 to 0x09 bit0.
REQ-015 Port: SCRATCH  out  32  scratch word, bytes 0x04(LSB)..0x07(MSB).

Function
REQ-016 FSM states IDLE, BUSY, ACK; reset state IDLE.
REQ-017 IDLE: RBCP_WE or RBCP_RE high, RBCP_ACT high, RBCP_ADDR[31:8]==BASE_ADDR -> latch offset, WD, direction; go to BUSY.
REQ-018 WE and RE high together -> treated as write only; exactly one ACK.
REQ-019 Address outside window -> no state change, no ACK (another slave answers).
REQ-020 BUSY: perform write or select read data; go to ACK next cycle.
REQ-021 ACK: RBCP_ACK=1 for exactly one cycle, RBCP_RD=selected byte; return to IDLE.
REQ-022 Latency fixed: strobe sampled at cycle N -> RBCP_ACK at cycle N+2; write-side effects visible at cycle N+2.
REQ-023 Strobes arriving in BUSY or ACK -> ignored, no queueing.
REQ-024 RBCP_ACT low in BUSY -> write not committed, ACK suppressed, return to IDLE.
REQ-025 Map: 0x00 DEVICE_ID RO; 0x01 VERSION RO; 0x04-0x07 SCRATCH RW; 0x08 bit0 CTRL_RUN RW, bits7:1 read 0; 0x09 WO pulse, reads 0; 0x10-0x13 counter snapshot RO.
REQ-026 Writes to RO or unmapped offsets ignored; reads of unmapped offsets return 8'h00; both still ACKed.
REQ-027 32-bit free-running cycle counter, +1 each cycle, wraps 32'hFFFFFFFF -> 0, unaffected by accesses.
REQ-028 Read of 0x10 returns counter[7:0] and latches counter[31:8] into shadow in the same BUSY cycle; 0x11-0x13 return shadow bytes 1-3, coherent until next 0x10 read.
REQ-029 CTRL_PULSE asserted in the cycle after the committing BUSY cycle, one cycle wide; write of 0 to 0x09 gives no pulse.

Reset
REQ-030 RSTn low -> immediately: FSM IDLE, RBCP_ACK=0, RBCP_RD=8'h00, CTRL_RUN=0, CTRL_PULSE=0, SCRATCH=32'h0, counter=0, shadow=0.
REQ-031 Reset during BUSY or ACK -> transaction aborted, no ACK after release.
REQ-032 First strobe accepted on the first rising edge with RSTn high.

Verification
REQ-033 Read 0x00, BASE_ADDR=0 -> ACK at N+2, RD=8'hA5; read 0x01 -> 8'h01.
REQ-034 Write 0x04..0x07 = 11,22,33,44 -> SCRATCH=32'h44332211; read-back each byte matches; each ACK at N+2.
REQ-035 Write 0x08=8'hFF -> CTRL_RUN=1, readback 8'h01; write 0x09=8'h01 -> one CTRL_PULSE cycle; write 0x09=8'h00 -> none.
REQ-036 Preload counter near 32'hFFFFFFFE, read 0x10..0x13 -> consistent snapshot across wrap; a second read of 0x11 returns the same byte.
REQ-037 Address 0x0000_0100 access -> no ACK; strobe during BUSY -> single ACK; WE+RE together -> write performed, one ACK.
REQ-038 RBCP_ACT dropped in BUSY, or RSTn pulsed in BUSY -> no ACK, no register change, outputs at reset values after reset.
